multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RV32I integer datapath: pc register, instruction ROM, register file, ALU and sign extender.
- Steps each instruction through FETCH, DECODE, EXEC and WB.
- Generates pc_write, instruction-register capture, register-file write enable, ALU opcode and ALU B-operand select.
- Decodes the R-type (0110011) and I-type ALU (0010011) subsets; halts on an all-zero instruction or an unsupported encoding.

---
 rtl/multicycle_control_if.sv | 59 +++++
 rtl/multicycle_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and its datapath and
// instruction memory. The master side is the sequencer.
interface multicycle_control_if #(
  parameter int unsigned RETIRE_W = 16
) ();

  logic                start;
  logic [31:0]         instr;
  logic                imem_valid;
  logic                ir_write;
  logic                pc_write;
  logic                rf_write_enable;
  logic [2:0]          alu_op;
  logic                alu_src_imm;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic                busy;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired_count;

  modport master (
    input  start,
    input  instr,
    input  imem_valid,
    output ir_write,
    output pc_write,
    output rf_write_enable,
    output alu_op,
    output alu_src_imm,
    output rs1,
    output rs2,
    output rd,
    output busy,
    output halted,
    output illegal,
    output retired_count
  );

  modport slave (
    output start,
    output instr,
    output imem_valid,
    input  ir_write,
    input  pc_write,
    input  rf_write_enable,
    input  alu_op,
    input  alu_src_imm,
    input  rs1,
    input  rs2,
    input  rd,
    input  busy,
    input  halted,
    input  illegal,
    input  retired_count
  );

endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> WB for the
// R-type and I-type ALU subsets. Halts on a zero word or unsupported encoding.
module multicycle_control #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         ir_q;
  logic [4:0]          rs1_q;
  logic [4:0]          rs2_q;
  logic [4:0]          rd_q;
  alu_op_t             alu_op_q;
  logic                alu_src_imm_q;
  logic                illegal_q;
  logic                pc_write_q;
  logic                rf_we_q;
  logic [RETIRE_W-1:0] retired_q;

  logic                dec_ok;
  alu_op_t             dec_op;
  logic                dec_imm;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Classify the latched instruction word and pick its ALU operation.
  always_comb begin
    dec_ok  = 1'b0;
    dec_op  = ALU_ADD;
    dec_imm = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO) begin
              dec_ok = 1'b1;
              dec_op = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              dec_ok = 1'b1;
              dec_op = ALU_SUB;
            end
          end
          3'b111: begin dec_op = ALU_AND; dec_ok = (funct7 == F7_ZERO); end
          3'b110: begin dec_op = ALU_OR;  dec_ok = (funct7 == F7_ZERO); end
          3'b100: begin dec_op = ALU_XOR; dec_ok = (funct7 == F7_ZERO); end
          3'b001: begin dec_op = ALU_SLL; dec_ok = (funct7 == F7_ZERO); end
          3'b101: begin dec_op = ALU_SRL; dec_ok = (funct7 == F7_ZERO); end
          3'b010: begin dec_op = ALU_SLT; dec_ok = (funct7 == F7_ZERO); end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_imm = 1'b1;
        case (funct3)
          // ADDI ignores bit 30: it is part of the immediate, not a funct7.
          3'b000: begin dec_op = ALU_ADD; dec_ok = 1'b1; end
          3'b111: begin dec_op = ALU_AND; dec_ok = 1'b1; end
          3'b110: begin dec_op = ALU_OR;  dec_ok = 1'b1; end
          3'b100: begin dec_op = ALU_XOR; dec_ok = 1'b1; end
          3'b010: begin dec_op = ALU_SLT; dec_ok = 1'b1; end
          3'b001: begin dec_op = ALU_SLL; dec_ok = (funct7 == F7_ZERO); end
          3'b101: begin dec_op = ALU_SRL; dec_ok = (funct7 == F7_ZERO); end
          default: dec_ok = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next-state sequencing; start is only honoured from IDLE or HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  if (bus.imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = dec_ok ? S_EXEC : S_HALT;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   if (bus.start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction register captures the word on the accepting FETCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ir_q <= '0;
    else if (state_q == S_FETCH && bus.imem_valid) ir_q <= bus.instr;
  end

  // Operand fields and ALU controls are held from DECODE until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_op_q      <= ALU_ADD;
      alu_src_imm_q <= 1'b0;
    end else if (state_q == S_DECODE && dec_ok) begin
      rs1_q         <= ir_q[19:15];
      rs2_q         <= ir_q[24:20];
      rd_q          <= ir_q[11:7];
      alu_op_q      <= dec_op;
      alu_src_imm_q <= dec_imm;
    end
  end

  // Sticky illegal flag: a zero word halts cleanly, anything else unsupported flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !dec_ok)  illegal_q <= (ir_q != '0);
    else if (state_q == S_HALT && bus.start)  illegal_q <= 1'b0;
  end

  // Write strobes are registered so they are high exactly during WB
  // (EXEC always advances to WB, so EXEC is the decode of "next is WB").
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write_q <= 1'b0;
      rf_we_q    <= 1'b0;
    end else begin
      pc_write_q <= (state_q == S_EXEC);
      rf_we_q    <= (state_q == S_EXEC) && (rd_q != '0);
    end
  end

  // Retired-instruction counter, wrapping modulo 2^RETIRE_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              retired_q <= '0;
    else if (state_q == S_WB) retired_q <= retired_q + RETIRE_W'(1);
  end

  assign bus.ir_write        = (state_q == S_FETCH) && bus.imem_valid;
  assign bus.pc_write        = pc_write_q;
  assign bus.rf_write_enable = rf_we_q;
  assign bus.alu_op          = alu_op_q;
  assign bus.alu_src_imm     = alu_src_imm_q;
  assign bus.rs1             = rs1_q;
  assign bus.rs2             = rs2_q;
  assign bus.rd              = rd_q;
  assign bus.busy            = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                               (state_q == S_EXEC)  || (state_q == S_WB);
  assign bus.halted          = (state_q == S_HALT);
  assign bus.illegal         = illegal_q;
  assign bus.retired_count   = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// expectations for each WB or HALT event; a monitor pops and compares them.
module tb_multicycle_control;

  logic clk;
  logic rst_n;

  multicycle_control_if #(.RETIRE_W(16)) bus ();
  multicycle_control_if #(.RETIRE_W(4))  wbus ();

  multicycle_control #(.RETIRE_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Narrow counter instance so wrap-around is reachable in a short run.
  multicycle_control #(.RETIRE_W(4)) wrap_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_halt;
    int         tag;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] op;
    logic       imm;
    logic       rfwe;
    logic       ill;
    int         ret;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_ret = 0;
  logic halted_d = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endfunction

  function automatic exp_t mk_wb(int tag, logic [4:0] rd, logic [4:0] rs1,
                                 logic [4:0] rs2, logic [2:0] op, logic imm);
    exp_t e;
    e.is_halt = 1'b0; e.tag = tag; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.op = op; e.imm = imm; e.rfwe = (rd != 5'd0); e.ill = 1'b0; e.ret = 0;
    return e;
  endfunction

  function automatic exp_t mk_halt(int tag, logic ill);
    exp_t e;
    e.is_halt = 1'b1; e.tag = tag; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    e.op = '0; e.imm = 1'b0; e.rfwe = 1'b0; e.ill = ill; e.ret = 0;
    return e;
  endfunction

  // Monitor: a WB strobe or entry into HALT consumes one expectation.
  always @(negedge clk) begin
    logic halt_edge;
    exp_t e;
    if (!rst_n) begin
      halted_d = 1'b0;
    end else begin
      halt_edge = bus.halted && !halted_d;
      halted_d  = bus.halted;
      if (bus.pc_write || bus.rf_write_enable || halt_edge) begin
        if (q.size() == 0) begin
          chk("spurious_event", {29'd0, bus.pc_write, bus.rf_write_enable, halt_edge}, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("ev%0d_kind_halt", e.tag), {31'd0, halt_edge}, {31'd0, e.is_halt});
          chk($sformatf("ev%0d_retired", e.tag), {16'd0, bus.retired_count}, e.ret);
          chk($sformatf("ev%0d_rf_we", e.tag), {31'd0, bus.rf_write_enable}, {31'd0, e.rfwe});
          if (e.is_halt) begin
            chk($sformatf("ev%0d_illegal", e.tag), {31'd0, bus.illegal}, {31'd0, e.ill});
            chk($sformatf("ev%0d_pc_write", e.tag), {31'd0, bus.pc_write}, 32'd0);
          end else begin
            chk($sformatf("ev%0d_rd", e.tag), {27'd0, bus.rd}, {27'd0, e.rd});
            chk($sformatf("ev%0d_rs1", e.tag), {27'd0, bus.rs1}, {27'd0, e.rs1});
            chk($sformatf("ev%0d_rs2", e.tag), {27'd0, bus.rs2}, {27'd0, e.rs2});
            chk($sformatf("ev%0d_alu_op", e.tag), {29'd0, bus.alu_op}, {29'd0, e.op});
            chk($sformatf("ev%0d_alu_src_imm", e.tag), {31'd0, bus.alu_src_imm}, {31'd0, e.imm});
          end
        end
      end
    end
  end

  // Issue one instruction from FETCH (entered at posedge+1) and wait for WB/HALT.
  task automatic issue(input logic [31:0] w, input int stall, input exp_t e);
    int cyc;
    exp_t ee;
    ee = e;
    ee.ret = exp_ret;
    q.push_back(ee);
    if (!e.is_halt) exp_ret++;
    bus.instr      = w;
    bus.imem_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk($sformatf("t%0d_stall_busy", e.tag), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("t%0d_stall_ir_write", e.tag), {31'd0, bus.ir_write}, 32'd0);
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b1;
    @(negedge clk);
    chk($sformatf("t%0d_ir_write", e.tag), {31'd0, bus.ir_write}, 32'd1);
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.pc_write && !bus.halted && cyc < 8);
    chk($sformatf("t%0d_latency", e.tag), cyc, e.is_halt ? 32'd2 : 32'd3);
    @(posedge clk); #1;
    chk($sformatf("t%0d_retired_after", e.tag), {16'd0, bus.retired_count}, exp_ret);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.instr = '0; bus.imem_valid = 1'b0;
    wbus.start = 1'b0; wbus.instr = '0; wbus.imem_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_halted", {31'd0, bus.halted}, 32'd0);
    chk("reset_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("reset_retired", {16'd0, bus.retired_count}, 32'd0);
    chk("reset_rd_rs1", {22'd0, bus.rd, bus.rs1}, 32'd0);
    chk("reset_strobes", {29'd0, bus.pc_write, bus.rf_write_enable, bus.ir_write}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    pulse_start();
    issue(32'h005303B3, 0, mk_wb(1, 5'd7, 5'd6, 5'd5, 3'd0, 1'b0));   // add x7,x6,x5
    issue(32'h403100B3, 0, mk_wb(2, 5'd1, 5'd2, 5'd3, 3'd1, 1'b0));   // sub x1,x2,x3
    issue(32'hFFF00293, 0, mk_wb(3, 5'd5, 5'd0, 5'd31, 3'd0, 1'b1));  // addi x5,x0,-1
    issue(32'h005303B3, 5, mk_wb(4, 5'd7, 5'd6, 5'd5, 3'd0, 1'b0));   // stalled add
    issue(32'h0030B133, 0, mk_halt(5, 1'b1));                         // sltu
    pulse_start();
    chk("restart_illegal_cleared", {31'd0, bus.illegal}, 32'd0);
    chk("restart_busy", {31'd0, bus.busy}, 32'd1);
    issue(32'h00000000, 0, mk_halt(6, 1'b0));                         // zero word
    pulse_start();
    issue(32'h00208033, 0, mk_wb(7, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0));   // add x0,x1,x2
    issue(32'h00221193, 0, mk_wb(8, 5'd3, 5'd4, 5'd2, 3'd5, 1'b1));   // slli x3,x4,2
    issue(32'h00A4C433, 0, mk_wb(9, 5'd8, 5'd9, 5'd10, 3'd4, 1'b0));  // xor x8,x9,x10
    issue(32'h4010D093, 0, mk_halt(10, 1'b1));                        // srai
    pulse_start();

    // Asynchronous reset while an add sits in EXEC: nothing may retire.
    bus.instr = 32'h005303B3;
    bus.imem_valid = 1'b1;
    @(negedge clk);
    chk("abort_ir_write", {31'd0, bus.ir_write}, 32'd1);
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_rd", {27'd0, bus.rd}, 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_strobes", {30'd0, bus.pc_write, bus.rf_write_enable}, 32'd0);
    chk("abort_fields", {19'd0, bus.rd, bus.rs1, bus.alu_op}, 32'd0);
    chk("abort_retired", {16'd0, bus.retired_count}, 32'd0);
    exp_ret = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_idle", {30'd0, bus.busy, bus.halted}, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);

    // Wrap-around on the 4-bit counter instance.
    @(posedge clk); #1;
    wbus.instr = 32'h00100093;   // addi x1,x0,1
    wbus.imem_valid = 1'b1;
    wbus.start = 1'b1;
    @(posedge clk); #1;
    wbus.start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!wbus.pc_write && cyc < 10);
      chk($sformatf("wrap_wb%0d_seen", i), {31'd0, wbus.pc_write}, 32'd1);
      @(negedge clk);
      chk($sformatf("wrap_count%0d", i), {28'd0, wbus.retired_count}, i % 16);
    end
    wbus.imem_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
